// File: rtl/output_buf_ctrl.sv
// Output-buffer sequencer: re-inits the buffer, waits out array latency, runs one
// column-capture load window, then drains DEPTH beats over valid/ready.
module output_buf_ctrl #(
  parameter int ARRAYWIDTH = 8,
  parameter int DSP_DELAY  = 3,
  parameter int DEPTH      = 8,
  parameter int LAT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LAT_W-1:0] compute_lat,
  output logic             busy,
  output logic             buf_clr,
  output logic             buf_load_en,
  output logic             buf_out_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             done,
  output logic             err_start
);

  localparam int LOAD_LEN = ARRAYWIDTH * DSP_DELAY;
  localparam int LOAD_W   = $clog2(LOAD_LEN + 1);
  localparam int BEAT_W   = $clog2(DEPTH + 1);

  localparam logic [LOAD_W-1:0] LOAD_LAST = LOAD_W'(LOAD_LEN - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    LOAD,
    DRAIN
  } state_t;

  state_t            state;
  logic [LAT_W-1:0]  lat_cnt;
  logic [LOAD_W-1:0] load_cnt;
  logic [BEAT_W-1:0] beat_cnt;
  logic [BEAT_W-1:0] beat_nxt;

  logic busy_q;
  logic load_en_q;
  logic out_valid_q;
  logic out_last_q;
  logic done_q;
  logic err_q;

  logic start_ok;
  logic beat_acc;

  always_comb begin
    start_ok   = start && (state == IDLE);
    beat_acc   = out_valid_q && out_ready;
    beat_nxt   = beat_cnt + BEAT_W'(1);
    // rst already re-inits the buffer, so the clear pulse is suppressed under it
    buf_clr    = start_ok && !rst;
    buf_out_en = beat_acc;
  end

  // Registered outputs are set on the transition into the state they describe,
  // so each one lines up with the state register in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      load_cnt    <= '0;
      beat_cnt    <= '0;
      busy_q      <= 1'b0;
      load_en_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= start && (state != IDLE);

      case (state)
        IDLE: begin
          if (start) begin
            lat_cnt  <= compute_lat;
            load_cnt <= '0;
            beat_cnt <= '0;
            busy_q   <= 1'b1;
            if (compute_lat != '0) begin
              state <= WAIT;
            end else begin
              state     <= LOAD;
              load_en_q <= 1'b1;
            end
          end
        end

        WAIT: begin
          lat_cnt <= lat_cnt - LAT_W'(1);
          if (lat_cnt == LAT_W'(1)) begin
            state     <= LOAD;
            load_en_q <= 1'b1;
          end
        end

        LOAD: begin
          if (load_cnt == LOAD_LAST) begin
            state       <= DRAIN;
            load_cnt    <= '0;
            load_en_q   <= 1'b0;
            out_valid_q <= 1'b1;
            out_last_q  <= (DEPTH == 1);
          end else begin
            load_cnt <= load_cnt + LOAD_W'(1);
          end
        end

        DRAIN: begin
          if (beat_acc) begin
            if (beat_cnt == BEAT_LAST) begin
              state       <= IDLE;
              beat_cnt    <= '0;
              busy_q      <= 1'b0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              beat_cnt   <= beat_nxt;
              out_last_q <= (beat_nxt == BEAT_LAST);
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign buf_load_en = load_en_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign done        = done_q;
  assign err_start   = err_q;

endmodule

// File: tb/tb_output_buf_ctrl.sv
// Scoreboard bench for output_buf_ctrl: a time-based reference model predicts every
// output each cycle and queues the expected drain beats / completions per tile.
module tb_output_buf_ctrl;

  localparam int AW    = 4;
  localparam int DD    = 3;
  localparam int DEPTH = 4;
  localparam int LW    = 16;
  localparam int WIN   = AW * DD;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] compute_lat;
  logic          busy;
  logic          buf_clr;
  logic          buf_load_en;
  logic          buf_out_en;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          done;
  logic          err_start;

  output_buf_ctrl #(
    .ARRAYWIDTH (AW),
    .DSP_DELAY  (DD),
    .DEPTH      (DEPTH),
    .LAT_W      (LW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .compute_lat (compute_lat),
    .busy        (busy),
    .buf_clr     (buf_clr),
    .buf_load_en (buf_load_en),
    .buf_out_en  (buf_out_en),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .done        (done),
    .err_start   (err_start)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected per-beat record queued when a tile is accepted
  typedef struct {
    int tile;
    bit last;
  } beat_t;

  beat_t beat_q[$];
  int    done_q[$];

  // Reference model: a tile is a start time plus latency; everything else is
  // derived from elapsed cycles and the count of accepted beats.
  int  cyc       = 0;
  bit  active    = 0;
  int  t0        = 0;
  int  lat       = 0;
  int  beats     = 0;
  int  tile_id   = 0;
  int  last_tile = -1;
  bit  done_p    = 0;
  bit  err_p     = 0;

  always @(negedge clk) begin
    automatic int         ph = cyc - t0;
    automatic bit         e_load, e_valid, e_last, e_clr, e_oen, was_active;
    automatic logic [7:0] e_vec, a_vec;
    automatic beat_t      b;
    automatic int         t;

    e_load  = active && ph >= lat + 1 && ph <= lat + WIN;
    e_valid = active && ph >= lat + WIN + 1;
    e_last  = e_valid && beats == DEPTH - 1;
    e_clr   = !active && start && !rst;
    e_oen   = e_valid && out_ready;
    e_vec   = {active, e_clr, e_load, e_oen, e_valid, e_last, done_p, err_p};
    a_vec   = {busy, buf_clr, buf_load_en, buf_out_en, out_valid, out_last, done, err_start};
    chk("outputs{busy,clr,load,oen,valid,last,done,err}", a_vec, e_vec);

    if (buf_out_en) begin
      if (beat_q.size() == 0) chk("beat_unexpected", 1, 0);
      else begin
        b = beat_q.pop_front();
        chk("beat_last_flag", out_last, b.last);
        if (b.last) last_tile = b.tile;
      end
    end
    if (done) begin
      if (done_q.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        t = done_q.pop_front();
        chk("done_after_last_beat", t, last_tile);
      end
    end

    was_active = active;
    if (rst) begin
      active = 0;
      done_p = 0;
      err_p  = 0;
      beat_q.delete();
      done_q.delete();
    end else begin
      err_p  = start && was_active;
      done_p = 0;
      if (e_oen) begin
        beats++;
        if (beats == DEPTH) begin
          active = 0;
          done_p = 1;
        end
      end
      if (!was_active && start) begin
        active = 1;
        t0     = cyc;
        lat    = int'(compute_lat);
        beats  = 0;
        tile_id++;
        for (int i = 0; i < DEPTH; i++) beat_q.push_back('{tile: tile_id, last: (i == DEPTH - 1)});
        done_q.push_back(tile_id);
      end
    end
    cyc++;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    start = 1'b0;
    repeat (k) cycle();
  endtask

  // Starts a tile in the current cycle and returns in the cycle done is seen.
  task automatic run_tile(input int l, input int exp_done, input int bp_lo, input int bp_hi,
                          input int extra_at, input string name);
    int n;
    bit seen;
    start       = 1'b1;
    compute_lat = LW'(l);
    out_ready   = 1'b1;
    n           = 0;
    seen        = 0;
    while (n < 70000 && !seen) begin
      cycle();
      n++;
      start     = (n == extra_at);
      out_ready = !(n >= bp_lo && n <= bp_hi);
      if (done) seen = 1;
    end
    chk({name, "_done_cycle"}, seen ? n : -1, exp_done);
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    compute_lat = '0;
    out_ready   = 1'b0;
    repeat (3) cycle();
    rst = 1'b0;
    idle(2);

    run_tile(5, 22, 1, 0, -1, "nominal");
    idle(3);
    run_tile(0, 17, 1, 0, -1, "zero_lat");
    idle(3);
    run_tile(5, 24, 19, 20, -1, "backpressure");
    idle(3);
    run_tile(5, 22, 1, 0, 10, "start_while_busy");
    run_tile(5, 22, 1, 0, -1, "back_to_back");
    idle(3);

    start       = 1'b1;
    compute_lat = LW'(5);
    out_ready   = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      cycle();
      start = 1'b0;
      if (n == 12) rst = 1'b1;
    end
    cycle();
    rst = 1'b0;
    chk("reset_mid_busy", busy, 0);
    cycle();
    run_tile(5, 22, 1, 0, -1, "after_reset");
    idle(3);

    run_tile(65535, 65536 + WIN + DEPTH, 1, 0, -1, "large_lat");
    idle(3);

    for (int i = 0; i < 600; i++) begin
      start       = ($urandom % 6 == 0);
      compute_lat = LW'($urandom % 10);
      out_ready   = ($urandom % 4 != 0);
      rst         = ($urandom % 150 == 0);
      cycle();
    end
    rst       = 1'b0;
    out_ready = 1'b1;
    idle(60);
    chk("beat_queue_drained", beat_q.size(), 0);
    chk("done_queue_drained", done_q.size(), 0);
    chk("idle_at_end", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
